// File: rtl/adc_set_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adc_set_arbiter
// Purpose  : Round-robin scheduler sharing one downstream sample path between
//            three sensor/ADC sets. Each set buffers one {pdata1,pdata0,pixel}
//            word; a registered valid/ready output presents the words tagged
//            with source set and pixel index.
// Ports    : clk_4M                 - system clock (rising edge)
//            reset                  - asynchronous active-low reset
//            set_enable[2:0]        - per-set enable (0 masks the set)
//            si_pulse[2:0]          - per-set SI pulse, clears pixel counter
//            new_data[2:0]          - per-set one-cycle sample strobe
//            pdata0_s0..s2          - channel-0 sample of each set
//            pdata1_s0..s2          - channel-1 sample of each set
//            out_valid/out_ready    - output handshake
//            out_data               - {pdata1, pdata0}
//            out_set                - source set 0..2
//            out_pixel              - pixel index of the word
//            overrun[2:0]           - sticky per-set overrun flags
//            drop_cnt[23:0]         - per-set saturating overrun counters
//                                     (only with ADC_ARB_DROP_CNT_EN defined)
// Options  : ADC_ARB_DROP_CNT_EN    - adds drop_cnt port and counters
// Revision : 1.0 - initial release
// ============================================================================
module adc_set_arbiter #(
  parameter int NUM_PIXELS = 128,
  parameter int PIX_W      = 8,
  parameter int DATA_W     = 12
) (
  input  logic                  clk_4M,
  input  logic                  reset,
  input  logic [2:0]            set_enable,
  input  logic [2:0]            si_pulse,
  input  logic [2:0]            new_data,
  input  logic [DATA_W-1:0]     pdata0_s0,
  input  logic [DATA_W-1:0]     pdata0_s1,
  input  logic [DATA_W-1:0]     pdata0_s2,
  input  logic [DATA_W-1:0]     pdata1_s0,
  input  logic [DATA_W-1:0]     pdata1_s1,
  input  logic [DATA_W-1:0]     pdata1_s2,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_data,
  output logic [1:0]            out_set,
  output logic [PIX_W-1:0]      out_pixel,
`ifdef ADC_ARB_DROP_CNT_EN
  output logic [23:0]           drop_cnt,
`endif
  output logic [2:0]            overrun
);

  localparam logic [PIX_W-1:0] c_last_pix = PIX_W'(NUM_PIXELS - 1);

  // Next set in round-robin order, k steps after base (base is 0..2).
  function automatic logic [1:0] f_rr(input logic [1:0] base, input int k);
    int s;
    s = (int'(base) + k) % 3;
    return s[1:0];
  endfunction

  // Per-set state
  logic [DATA_W-1:0] r_hold_d0  [3];
  logic [DATA_W-1:0] r_hold_d1  [3];
  logic [PIX_W-1:0]  r_hold_pix [3];
  logic [PIX_W-1:0]  r_cnt      [3];
  logic [2:0]        r_pending;
  logic [1:0]        r_last_grant;

  // Input samples gathered into arrays for indexed access
  logic [DATA_W-1:0] w_pd0 [3];
  logic [DATA_W-1:0] w_pd1 [3];
  assign w_pd0[0] = pdata0_s0;
  assign w_pd0[1] = pdata0_s1;
  assign w_pd0[2] = pdata0_s2;
  assign w_pd1[0] = pdata1_s0;
  assign w_pd1[1] = pdata1_s1;
  assign w_pd1[2] = pdata1_s2;

  logic [2:0] w_capture;
  logic [2:0] w_req;
  logic       w_load_ok;
  logic       w_grant_any;
  logic [1:0] w_grant_idx;
  logic       w_grant;
  logic [2:0] w_grant_vec;
  logic [2:0] w_overrun_ev;

  assign w_capture = new_data & set_enable;
  // A disabled set never competes, even in the cycle its pending bit clears.
  assign w_req     = r_pending & set_enable;
  assign w_load_ok = ~out_valid | out_ready;

  // Scan from the farthest candidate down to last_grant+1 so the nearest
  // pending set overrides the others.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      if (w_req[f_rr(r_last_grant, k)]) begin
        w_grant_any = 1'b1;
        w_grant_idx = f_rr(r_last_grant, k);
      end
    end
  end

  assign w_grant     = w_load_ok & w_grant_any;
  assign w_grant_vec = w_grant ? (3'b001 << w_grant_idx) : 3'b000;
  // A capture into the set being granted this cycle is not an overrun: the
  // old word leaves while the new one takes its place.
  assign w_overrun_ev = w_capture & r_pending & ~w_grant_vec;

  always_ff @(posedge clk_4M or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_set      <= 2'd0;
      out_pixel    <= '0;
      overrun      <= 3'b000;
      r_pending    <= 3'b000;
      r_last_grant <= 2'd2;
      for (int i = 0; i < 3; i++) begin
        r_hold_d0[i]  <= '0;
        r_hold_d1[i]  <= '0;
        r_hold_pix[i] <= '0;
        r_cnt[i]      <= '0;
      end
    end else begin
      // Output register: load a new word or retire the accepted one; the
      // fields stay put while stalled.
      if (w_grant) begin
        out_valid    <= 1'b1;
        out_data     <= {r_hold_d1[w_grant_idx], r_hold_d0[w_grant_idx]};
        out_set      <= w_grant_idx;
        out_pixel    <= r_hold_pix[w_grant_idx];
        r_last_grant <= w_grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      for (int i = 0; i < 3; i++) begin
        if (!set_enable[i]) begin
          r_pending[i] <= 1'b0;
        end else if (w_capture[i]) begin
          r_pending[i] <= 1'b1;
        end else if (w_grant_vec[i]) begin
          r_pending[i] <= 1'b0;
        end

        if (w_capture[i]) begin
          r_hold_d0[i]  <= w_pd0[i];
          r_hold_d1[i]  <= w_pd1[i];
          r_hold_pix[i] <= si_pulse[i] ? '0 : r_cnt[i];
        end

        // SI restarts the frame; a coincident sample consumes index 0.
        if (si_pulse[i]) begin
          r_cnt[i] <= w_capture[i] ? PIX_W'(1) : '0;
        end else if (w_capture[i]) begin
          r_cnt[i] <= (r_cnt[i] == c_last_pix) ? '0 : r_cnt[i] + 1'b1;
        end

        if (w_overrun_ev[i]) begin
          overrun[i] <= 1'b1;
        end
      end
    end
  end

`ifdef ADC_ARB_DROP_CNT_EN
  logic [7:0] r_drop [3];

  always_ff @(posedge clk_4M or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        r_drop[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_overrun_ev[i] && (r_drop[i] != 8'hFF)) begin
          r_drop[i] <= r_drop[i] + 8'd1;
        end
      end
    end
  end

  assign drop_cnt = {r_drop[2], r_drop[1], r_drop[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_set_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_set_arbiter
// Purpose  : Self-checking bench for adc_set_arbiter: directed scenarios plus
//            randomized traffic compared against a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_set_arbiter;

  localparam int NUM_PIXELS = 128;
  localparam int PIX_W      = 8;
  localparam int DATA_W     = 12;

  logic              clk_4M = 1'b0;
  logic              reset;
  logic [2:0]        set_enable, si_pulse, new_data;
  logic [DATA_W-1:0] pdata0_s0, pdata0_s1, pdata0_s2;
  logic [DATA_W-1:0] pdata1_s0, pdata1_s1, pdata1_s2;
  logic              out_ready;
  logic              out_valid;
  logic [23:0]       out_data;
  logic [1:0]        out_set;
  logic [7:0]        out_pixel;
  logic [2:0]        overrun;
`ifdef ADC_ARB_DROP_CNT_EN
  logic [23:0]       drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_4M = ~clk_4M;

  adc_set_arbiter #(.NUM_PIXELS(NUM_PIXELS), .PIX_W(PIX_W), .DATA_W(DATA_W)) dut (
    .clk_4M     (clk_4M),
    .reset      (reset),
    .set_enable (set_enable),
    .si_pulse   (si_pulse),
    .new_data   (new_data),
    .pdata0_s0  (pdata0_s0),
    .pdata0_s1  (pdata0_s1),
    .pdata0_s2  (pdata0_s2),
    .pdata1_s0  (pdata1_s0),
    .pdata1_s1  (pdata1_s1),
    .pdata1_s2  (pdata1_s2),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_set    (out_set),
    .out_pixel  (out_pixel),
`ifdef ADC_ARB_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .overrun    (overrun)
  );

  // ---------------- reference model (word level) ----------------
  bit          m_ov;
  logic [23:0] m_od;
  int          m_os, m_op, m_last;
  bit          m_has  [3];
  logic [23:0] m_word [3];
  int          m_pix  [3];
  int          m_cnt  [3];
  logic [2:0]  m_ovr;
  int          m_drop [3];

  function automatic logic [23:0] sample_of(input int s);
    case (s)
      0:       return {pdata1_s0, pdata0_s0};
      1:       return {pdata1_s1, pdata0_s1};
      default: return {pdata1_s2, pdata0_s2};
    endcase
  endfunction

  task automatic model_reset();
    m_ov = 0; m_od = '0; m_os = 0; m_op = 0; m_last = 2; m_ovr = 3'b000;
    for (int s = 0; s < 3; s++) begin
      m_has[s] = 0; m_word[s] = '0; m_pix[s] = 0; m_cnt[s] = 0; m_drop[s] = 0;
    end
  endtask

  // One clock of the rules: who gets the output slot, then what each set's
  // buffer and pixel counter become.
  task automatic model_update();
    bit load_ok, cap;
    int g;
    load_ok = !m_ov || out_ready;
    g = -1;
    if (load_ok) begin
      for (int k = 1; k <= 3; k++) begin
        int s;
        s = (m_last + k) % 3;
        if (g < 0 && m_has[s] && set_enable[s]) g = s;
      end
    end
    if (g >= 0) begin
      m_ov = 1; m_od = m_word[g]; m_os = g; m_op = m_pix[g]; m_last = g;
    end else if (out_ready) begin
      m_ov = 0;
    end
    for (int s = 0; s < 3; s++) begin
      cap = new_data[s] && set_enable[s];
      if (!set_enable[s]) begin
        m_has[s] = 0;
      end else if (cap) begin
        if (m_has[s] && g != s) begin
          m_ovr[s] = 1'b1;
          if (m_drop[s] < 255) m_drop[s]++;
        end
        m_has[s]  = 1;
        m_word[s] = sample_of(s);
        m_pix[s]  = si_pulse[s] ? 0 : m_cnt[s];
      end else if (g == s) begin
        m_has[s] = 0;
      end
      if (si_pulse[s]) m_cnt[s] = cap ? 1 : 0;
      else if (cap)    m_cnt[s] = (m_cnt[s] + 1) % NUM_PIXELS;
    end
  endtask

  task automatic step();
    @(posedge clk_4M);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_4M);
    reset = 1'b0;
    new_data = 3'b000; si_pulse = 3'b000;
    model_reset();
    repeat (2) @(posedge clk_4M);
    @(negedge clk_4M);
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0 || out_data !== 24'h0 || out_set !== 2'd0 ||
        out_pixel !== 8'd0 || overrun !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b d=%h s=%0d p=%0d o=%b want all zero",
               out_valid, out_data, out_set, out_pixel, overrun);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_enable = 3'b001; out_ready = 1'b1;
    pdata0_s0 = 12'h123; pdata1_s0 = 12'hABC;
    new_data = 3'b001;
    step();
    new_data = 3'b000;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_early: out_valid=%0b want 0", out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 24'hABC123 || out_set !== 2'd0 || out_pixel !== 8'd0) begin
      bad++;
      $display("FAIL single_word: got v=%0b d=%h s=%0d p=%0d want v=1 d=abc123 s=0 p=0",
               out_valid, out_data, out_set, out_pixel);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_retire: out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [23:0] exp_d;
    do_reset();
    set_enable = 3'b111; out_ready = 1'b1;
    pdata0_s0 = 12'h010; pdata1_s0 = 12'h0A0;
    pdata0_s1 = 12'h011; pdata1_s1 = 12'h0A1;
    pdata0_s2 = 12'h012; pdata1_s2 = 12'h0A2;
    for (int rep = 0; rep < 2; rep++) begin
      new_data = 3'b111;
      step();
      new_data = 3'b000;
      for (int k = 0; k < 3; k++) begin
        step();
        exp_d = {12'h0A0 + 12'(k), 12'h010 + 12'(k)};
        total++;
        if (out_valid !== 1'b1 || out_set !== 2'(k) || out_data !== exp_d) begin
          bad++;
          $display("FAIL rr_order rep%0d: got v=%0b s=%0d d=%h want v=1 s=%0d d=%h",
                   rep, out_valid, out_set, out_data, k, exp_d);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] held_d;
    int stable_bad;
    do_reset();
    set_enable = 3'b001; out_ready = 1'b0;
    pdata0_s0 = 12'h111; pdata1_s0 = 12'h222;
    new_data = 3'b001;
    step();
    new_data = 3'b000;
    step();
    held_d = out_data;
    total++;
    if (out_valid !== 1'b1 || held_d !== 24'h222111) begin
      bad++; $display("FAIL bp_first: got v=%0b d=%h want v=1 d=222111", out_valid, held_d);
    end
    stable_bad = 0;
    for (int c = 0; c < 10; c++) begin
      new_data = 3'b000;
      if (c == 2) begin new_data = 3'b001; pdata0_s0 = 12'h333; pdata1_s0 = 12'h444; end
      if (c == 5) begin new_data = 3'b001; pdata0_s0 = 12'h555; pdata1_s0 = 12'h666; end
      step();
      if (out_valid !== 1'b1 || out_data !== 24'h222111 || out_set !== 2'd0 || out_pixel !== 8'd0)
        stable_bad++;
      if (c == 2) begin
        total++;
        if (overrun !== 3'b000) begin
          bad++; $display("FAIL bp_no_overrun: overrun=%b want 000", overrun);
        end
      end
      if (c == 5) begin
        total++;
        if (overrun !== 3'b001) begin
          bad++; $display("FAIL bp_overrun: overrun=%b want 001", overrun);
        end
      end
    end
    new_data = 3'b000;
    total++;
    if (stable_bad != 0) begin
      bad++; $display("FAIL bp_stable: %0d unstable cycles want 0", stable_bad);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 24'h666555 || out_pixel !== 8'd2) begin
      bad++;
      $display("FAIL bp_newer: got v=%0b d=%h p=%0d want v=1 d=666555 p=2",
               out_valid, out_data, out_pixel);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || overrun !== 3'b001) begin
      bad++; $display("FAIL bp_after: got v=%0b o=%b want v=0 o=001", out_valid, overrun);
    end
  endtask

  task automatic test_pixel_wrap();
    int k, seq_bad;
    do_reset();
    set_enable = 3'b010; out_ready = 1'b1;
    k = 0; seq_bad = 0;
    for (int j = 0; j < 132; j++) begin
      new_data = (j < 130) ? 3'b010 : 3'b000;
      pdata0_s1 = 12'(j); pdata1_s1 = 12'(j + 7);
      step();
      if (out_valid === 1'b1) begin
        if (out_set !== 2'd1 || out_pixel !== 8'(k % NUM_PIXELS)) begin
          seq_bad++;
          if (seq_bad < 4)
            $display("FAIL wrap_pixel word%0d: got s=%0d p=%0d want s=1 p=%0d",
                     k, out_set, out_pixel, k % NUM_PIXELS);
        end
        k++;
      end
    end
    total++;
    if (seq_bad != 0 || k != 130) begin
      bad++; $display("FAIL wrap_count: words=%0d errors=%0d want words=130 errors=0", k, seq_bad);
    end
    new_data = 3'b010; si_pulse = 3'b010;
    step();
    si_pulse = 3'b000;
    step();
    new_data = 3'b000;
    total++;
    if (out_valid !== 1'b1 || out_pixel !== 8'd0) begin
      bad++; $display("FAIL si_zero: got v=%0b p=%0d want v=1 p=0", out_valid, out_pixel);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_pixel !== 8'd1) begin
      bad++; $display("FAIL si_next: got v=%0b p=%0d want v=1 p=1", out_valid, out_pixel);
    end
  endtask

  task automatic test_mask_and_reset();
    int seen;
    do_reset();
    set_enable = 3'b011; out_ready = 1'b1;
    new_data = 3'b100;
    seen = 0;
    step();
    new_data = 3'b000;
    for (int c = 0; c < 3; c++) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL mask_no_word: %0d valid cycles want 0", seen);
    end
    set_enable = 3'b111;
    new_data = 3'b111;
    step();
    new_data = 3'b000;
    step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL rst_pre: out_valid=%0b want 1", out_valid);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_async: out_valid=%0b want 0", out_valid);
    end
    @(posedge clk_4M);
    @(negedge clk_4M);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_flush: %0d valid cycles after release want 0", seen);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_enable = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111;
      new_data   = 3'($urandom);
      si_pulse   = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      out_ready  = ($urandom_range(0, 9) < 7);
      pdata0_s0 = 12'($urandom); pdata0_s1 = 12'($urandom); pdata0_s2 = 12'($urandom);
      pdata1_s0 = 12'($urandom); pdata1_s1 = 12'($urandom); pdata1_s2 = 12'($urandom);
      step();
      total++;
      if (out_valid !== m_ov) begin
        bad++; $display("FAIL rand_valid c%0d: got %0b want %0b", c, out_valid, m_ov);
      end else if (m_ov) begin
        total++;
        if (out_data !== m_od || out_set !== m_os[1:0] || out_pixel !== m_op[7:0]) begin
          bad++;
          $display("FAIL rand_word c%0d: got d=%h s=%0d p=%0d want d=%h s=%0d p=%0d",
                   c, out_data, out_set, out_pixel, m_od, m_os, m_op);
        end
      end
      total++;
      if (overrun !== m_ovr) begin
        bad++; $display("FAIL rand_overrun c%0d: got %b want %b", c, overrun, m_ovr);
      end
`ifdef ADC_ARB_DROP_CNT_EN
      total++;
      if (drop_cnt !== {8'(m_drop[2]), 8'(m_drop[1]), 8'(m_drop[0])}) begin
        bad++; $display("FAIL rand_drop c%0d: got %h", c, drop_cnt);
      end
`endif
    end
    new_data = 3'b000; si_pulse = 3'b000;
  endtask

`ifdef ADC_ARB_DROP_CNT_EN
  task automatic test_drop_cnt();
    do_reset();
    set_enable = 3'b010; out_ready = 1'b0;
    new_data = 3'b010;
    repeat (302) step();
    new_data = 3'b000;
    total++;
    if (drop_cnt !== 24'h00FF00 || overrun !== 3'b010) begin
      bad++; $display("FAIL drop_sat: got cnt=%h o=%b want cnt=00ff00 o=010", drop_cnt, overrun);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    set_enable = 3'b000; si_pulse = 3'b000; new_data = 3'b000; out_ready = 1'b0;
    pdata0_s0 = '0; pdata0_s1 = '0; pdata0_s2 = '0;
    pdata1_s0 = '0; pdata1_s1 = '0; pdata1_s2 = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pixel_wrap();
    test_mask_and_reset();
    test_random();
`ifdef ADC_ARB_DROP_CNT_EN
    test_drop_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
